// File: rtl/div32_signed_ctrl_pkg.sv
// Shared definitions for the signed divide sequencer: state encoding, widths,
// special-case result constants and status flag positions.
package div_pkg;

   localparam int DIV_W = 32;

   localparam logic [DIV_W-1:0] DZ_QUOT  = 32'hFFFF_FFFF;
   localparam logic [DIV_W-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [DIV_W-1:0] MINUS_1  = 32'hFFFF_FFFF;

   localparam int FLAG_DZ  = 0;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_ERR = 2;
   localparam int FLAG_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ARM   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_FIX   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // The single signed quotient that does not fit in 32 bits.
   function automatic logic is_signed_ovf(input logic sgn,
                                          input logic [DIV_W-1:0] a,
                                          input logic [DIV_W-1:0] b);
      return sgn && (a == INT_MIN) && (b == MINUS_1);
   endfunction

endpackage

// File: rtl/div32_signed_ctrl_neg32_cond.sv
// Conditional two's-complement negate: y = en ? -x : x, wrapping at DIV_W bits.
module neg32_cond
   import div_pkg::*;
(
   input  logic             en,
   input  logic [DIV_W-1:0] x,
   output logic [DIV_W-1:0] y
);

   assign y = en ? (~x + {{(DIV_W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/div32_signed_ctrl.sv
// Issue/sequencing stage in front of an unsigned divider: magnitude conversion,
// start/finish handshake, sign fix-up, and local divide-by-zero/overflow/timeout handling.
module div32_signed_ctrl
   import div_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 128
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [DIV_W-1:0] in_a,
   input  logic [DIV_W-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIV_W-1:0] out_q,
   output logic [DIV_W-1:0] out_r,
   output logic             out_dz,
   output logic             out_ovf,
   output logic             out_err,
   output logic [DIV_W-1:0] div_a,
   output logic [DIV_W-1:0] div_b,
   output logic             div_start,
   input  logic [DIV_W-1:0] div_q,
   input  logic [DIV_W-1:0] div_r,
   input  logic             div_finish
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic              sa;
   logic              sb;
   logic [DIV_W-1:0]  q_cap;
   logic [DIV_W-1:0]  r_cap;
   logic [CNT_W-1:0]  tcnt;
   logic [FLAG_W-1:0] flags;

   logic              accept;
   logic              in_sa;
   logic              in_sb;
   logic              in_dz;
   logic              in_ovf;
   logic              timeout_hit;
   logic [DIV_W-1:0]  neg_a;
   logic [DIV_W-1:0]  neg_b;
   logic [DIV_W-1:0]  fix_q;
   logic [DIV_W-1:0]  fix_r;

   assign accept      = (state == ST_IDLE) && in_valid;
   assign in_sa       = in_signed & in_a[DIV_W-1];
   assign in_sb       = in_signed & in_b[DIV_W-1];
   assign in_dz       = (in_b == '0);
   assign in_ovf      = is_signed_ovf(in_signed, in_a, in_b);
   assign timeout_hit = (tcnt == CNT_LAST);

   neg32_cond u_neg_a (.en(in_sa),   .x(in_a),  .y(neg_a));
   neg32_cond u_neg_b (.en(in_sb),   .x(in_b),  .y(neg_b));
   neg32_cond u_neg_q (.en(sa ^ sb), .x(q_cap), .y(fix_q));
   neg32_cond u_neg_r (.en(sa),      .x(r_cap), .y(fix_r));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ARM holds off until a finish left over from the previous op has dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (in_dz || in_ovf) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_START;
               end
            end
         end
         ST_START: state_nxt = ST_ARM;
         ST_ARM: begin
            if (timeout_hit) begin
               state_nxt = ST_DONE;
            end else if (!div_finish) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (div_finish) begin
               state_nxt = ST_FIX;
            end else if (timeout_hit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_FIX: state_nxt = ST_DONE;
         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      div_start = 1'b0;
      case (state)
         ST_IDLE:  in_ready  = 1'b1;
         ST_START: div_start = 1'b1;
         ST_DONE:  out_valid = 1'b1;
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa    <= 1'b0;
         sb    <= 1'b0;
         div_a <= '0;
         div_b <= '0;
         q_cap <= '0;
         r_cap <= '0;
         out_q <= '0;
         out_r <= '0;
         tcnt  <= '0;
         flags <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (in_dz) begin
                     out_q          <= DZ_QUOT;
                     out_r          <= in_a;
                     flags          <= '0;
                     flags[FLAG_DZ] <= 1'b1;
                  end else if (in_ovf) begin
                     out_q           <= INT_MIN;
                     out_r           <= '0;
                     flags           <= '0;
                     flags[FLAG_OVF] <= 1'b1;
                  end else begin
                     sa    <= in_sa;
                     sb    <= in_sb;
                     div_a <= neg_a;
                     div_b <= neg_b;
                  end
               end
            end
            ST_START: tcnt <= '0;
            ST_ARM: begin
               if (timeout_hit) begin
                  out_q           <= '0;
                  out_r           <= '0;
                  flags           <= '0;
                  flags[FLAG_ERR] <= 1'b1;
               end else begin
                  tcnt <= tcnt + CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (div_finish) begin
                  q_cap <= div_q;
                  r_cap <= div_r;
               end else if (timeout_hit) begin
                  out_q           <= '0;
                  out_r           <= '0;
                  flags           <= '0;
                  flags[FLAG_ERR] <= 1'b1;
               end else begin
                  tcnt <= tcnt + CNT_W'(1);
               end
            end
            ST_FIX: begin
               out_q <= fix_q;
               out_r <= fix_r;
               flags <= '0;
            end
            ST_DONE: begin
               if (out_ready) begin
                  flags <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_dz  = flags[FLAG_DZ];
   assign out_ovf = flags[FLAG_OVF];
   assign out_err = flags[FLAG_ERR];

endmodule

// File: tb/tb_div32_signed_ctrl.sv
// Bench for div32_signed_ctrl with a behavioural unsigned divider behind it;
// expected results are queued at issue and checked by an independent monitor.
module tb_div32_signed_ctrl;

   localparam int TMO = 128;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ovf;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_signed = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_q;
   logic [31:0] out_r;
   logic        out_dz;
   logic        out_ovf;
   logic        out_err;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_start;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_finish;

   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [31:0] m_q = '0;
   logic [31:0] m_r = '0;
   logic        m_finish = 1'b0;
   logic        m_clr = 1'b0;
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   logic        div_stuck = 1'b0;

   int   checks = 0;
   int   failures = 0;
   int   starts = 0;
   exp_t sb[$];

   div32_signed_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_r(out_r),
      .out_dz(out_dz), .out_ovf(out_ovf), .out_err(out_err),
      .div_a(div_a), .div_b(div_b), .div_start(div_start),
      .div_q(div_q), .div_r(div_r), .div_finish(div_finish)
   );

   always #5 clk = ~clk;

   // Divider stand-in: samples start on negedge, drops finish one cycle late so a
   // stale finish is visible while the controller is in ARM.
   always @(negedge clk) begin
      if (div_start) begin
         m_a    <= div_a;
         m_b    <= div_b;
         m_cnt  <= 0;
         m_busy <= 1'b1;
         m_clr  <= 1'b1;
      end else begin
         if (m_clr) begin
            m_finish <= 1'b0;
            m_clr    <= 1'b0;
         end
         if (m_busy) begin
            if (m_cnt == 33) begin
               m_q      <= (m_b != 0) ? m_a / m_b : 32'hFFFF_FFFF;
               m_r      <= (m_b != 0) ? m_a % m_b : m_a;
               m_finish <= 1'b1;
               m_busy   <= 1'b0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   assign div_q      = m_q;
   assign div_r      = m_r;
   assign div_finish = div_stuck ? 1'b0 : m_finish;

   always @(negedge clk) begin
      if (div_start) starts <= starts + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output is popped and compared against the queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("q", out_q, e.q);
            checkOutput("r", out_r, e.r);
            checkOutput("flags", {29'd0, out_dz, out_ovf, out_err}, {29'd0, e.dz, e.ovf, e.err});
         end
      end
   end

   function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r,
                               input logic dz, input logic ovf, input logic err);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.ovf = ovf; e.err = err;
      return e;
   endfunction

   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic push, input exp_t e);
      int n;
      n = 0;
      while (!in_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_timeout", 32'd0, 32'd1);
      end else begin
         in_valid  = 1'b1;
         in_signed = s;
         in_a      = a;
         in_b      = b;
         if (push) sb.push_back(e);
         @(posedge clk); #1;
         in_valid  = 1'b0;
         in_signed = ~s;
         in_a      = 32'hDEAD_BEEF;
         in_b      = 32'h0;
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0 || !in_ready) begin
         checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      checkOutput({tag, "_div_start"}, {31'd0, div_start}, 32'd0);
      checkOutput({tag, "_out_q"}, out_q, 32'd0);
      checkOutput({tag, "_out_r"}, out_r, 32'd0);
      checkOutput({tag, "_flags"}, {29'd0, out_dz, out_ovf, out_err}, 32'd0);
      checkOutput({tag, "_div_a"}, div_a, 32'd0);
      checkOutput({tag, "_div_b"}, div_b, 32'd0);
   endtask

   initial begin
      int n;
      int s0;
      #2 rst_n = 1'b0;
      #1 checkResetValues("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(1'b1, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 0, 0, 0));
      applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0, 0));
      applyStimulus(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, mk(32'hFFFF_FFF2, 32'd2, 0, 0, 0));
      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, mk(32'd3, 32'hFFFF_FFFF, 0, 0, 0));
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd16, 1'b1, mk(32'h0FFF_FFFF, 32'd15, 0, 0, 0));
      waitDrain();

      for (int m = 0; m < 2; m++) begin
         s0 = starts;
         applyStimulus(m[0], 32'd5, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'd5, 1, 0, 0));
         checkOutput("dz_latency", {31'd0, out_valid}, 32'd1);
         waitDrain();
         checkOutput("dz_no_start", 32'(starts - s0), 32'd0);
      end

      s0 = starts;
      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 0, 1, 0));
      waitDrain();
      checkOutput("ovf_no_start", 32'(starts - s0), 32'd0);
      applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'd0, 32'h8000_0000, 0, 0, 0));

      applyStimulus(1'b1, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 0, 0, 0));
      applyStimulus(1'b1, 32'd9, 32'd3, 1'b1, mk(32'd3, 32'd0, 0, 0, 0));
      waitDrain();

      out_ready = 1'b0;
      applyStimulus(1'b1, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 0, 0, 0));
      n = 0;
      while (!out_valid && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("hold_valid_seen", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("hold_q", out_q, 32'd14);
         checkOutput("hold_r", out_r, 32'd2);
      end
      out_ready = 1'b1;
      waitDrain();

      div_stuck = 1'b1;
      applyStimulus(1'b0, 32'd5, 32'd3, 1'b1, mk(32'd0, 32'd0, 0, 0, 1));
      n = 0;
      while (!out_valid && n < 4 * TMO) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("timeout_cycles", 32'(n), 32'(TMO + 1));
      waitDrain();
      div_stuck = 1'b0;

      applyStimulus(1'b0, 32'd7, 32'd3, 1'b0, mk(32'd0, 32'd0, 0, 0, 0));
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 checkResetValues("midop_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      applyStimulus(1'b0, 32'd7, 32'd2, 1'b1, mk(32'd3, 32'd1, 0, 0, 0));
      waitDrain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
